// File: rtl/hop_lane_if.sv
// Handshake/status bundle between the hop-chain stimulus side and hop_lane_checker.
interface hop_lane_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 16
);
    logic             en;
    logic             clear;
    logic [LANES-1:0] lane_in;
    logic [LANES-1:0] lane_out;
    logic [LANES-1:0] lane_mask;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [LANES-1:0] err_lane;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] ones_count;

    modport master (
        output en, clear, lane_in, lane_out, lane_mask,
        input  busy, done, pass, fail, err_lane, err_count, ones_count
    );

    modport slave (
        input  en, clear, lane_in, lane_out, lane_mask,
        output busy, done, pass, fail, err_lane, err_count, ones_count
    );
endinterface

// File: rtl/hop_lane_checker.sv
// Monitor for the 4-lane hop-chain benchmark: delays the lane stimuli through a reference
// line, compares against the chain tails and accumulates sticky flags and saturating counts.
module hop_lane_checker #(
    parameter int unsigned HOP_LAT = 6,
    parameter int unsigned LANES   = 4,
    parameter int unsigned CNT_W   = 16
) (
    input logic       clock0,
    input logic       rst1,
    hop_lane_if.slave bus
);
    localparam int unsigned CW = $clog2(HOP_LAT);
    localparam int unsigned SW = CNT_W + 1;
    localparam logic [CW-1:0] LAST = CW'(HOP_LAT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WARM  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [LANES-1:0] r_ref [HOP_LAT];
    logic [LANES-1:0] r_err_lane;
    logic             r_fail;
    logic [CNT_W-1:0] r_err_count;
    logic [CNT_W-1:0] r_ones_count;

    logic [2:0]       w_state_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_start;
    logic             w_cmp;
    logic [LANES-1:0] w_tail;
    logic [LANES-1:0] w_mis;
    logic [LANES-1:0] w_one;
    logic [SW-1:0]    w_mis_pop;
    logic [SW-1:0]    w_one_pop;
    logic [SW-1:0]    w_err_sum;
    logic [SW-1:0]    w_ones_sum;
    logic [CNT_W-1:0] w_err_nxt;
    logic [CNT_W-1:0] w_ones_nxt;

    // Run sequencing; the shared counter times both the warm-up and the drain window.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_start     = 1'b0;
        w_cmp       = 1'b0;
        if (bus.clear) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.en) begin
                        w_state_nxt = S_WARM;
                        w_cnt_nxt   = '0;
                        w_start     = 1'b1;
                    end
                end
                S_WARM: begin
                    if (r_cnt == LAST) begin
                        w_state_nxt = S_CHECK;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                S_CHECK: begin
                    w_cmp = 1'b1;
                    if (!bus.en) begin
                        w_state_nxt = S_DRAIN;
                        w_cnt_nxt   = '0;
                    end
                end
                S_DRAIN: begin
                    w_cmp = 1'b1;
                    if (r_cnt == LAST) begin
                        w_state_nxt = S_DONE;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Reference delay line runs in every state so it is already primed when compares begin.
    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            for (int k = 0; k < HOP_LAT; k++) r_ref[k] <= '0;
        end else begin
            r_ref[0] <= bus.lane_in;
            for (int k = 1; k < HOP_LAT; k++) r_ref[k] <= r_ref[k-1];
        end
    end

    always_comb begin
        w_tail    = r_ref[HOP_LAT-1];
        w_mis     = (bus.lane_out ^ w_tail) & ~bus.lane_mask;
        w_one     = bus.lane_out & w_tail & ~bus.lane_mask;
        w_mis_pop = '0;
        w_one_pop = '0;
        for (int i = 0; i < LANES; i++) begin
            w_mis_pop = w_mis_pop + SW'(w_mis[i]);
            w_one_pop = w_one_pop + SW'(w_one[i]);
        end
        // One extra bit catches the carry so the counters clamp instead of wrapping.
        w_err_sum  = {1'b0, r_err_count} + w_mis_pop;
        w_ones_sum = {1'b0, r_ones_count} + w_one_pop;
        w_err_nxt  = w_err_sum[CNT_W]  ? {CNT_W{1'b1}} : w_err_sum[CNT_W-1:0];
        w_ones_nxt = w_ones_sum[CNT_W] ? {CNT_W{1'b1}} : w_ones_sum[CNT_W-1:0];
    end

    always_ff @(posedge clock0 or posedge rst1) begin
        if (rst1) begin
            r_err_lane   <= '0;
            r_fail       <= 1'b0;
            r_err_count  <= '0;
            r_ones_count <= '0;
        end else if (bus.clear || w_start) begin
            r_err_lane   <= '0;
            r_fail       <= 1'b0;
            r_err_count  <= '0;
            r_ones_count <= '0;
        end else if (w_cmp) begin
            r_err_lane   <= r_err_lane | w_mis;
            r_fail       <= r_fail | (|w_mis);
            r_err_count  <= w_err_nxt;
            r_ones_count <= w_ones_nxt;
        end
    end

    assign bus.busy       = (r_state == S_WARM) || (r_state == S_CHECK) || (r_state == S_DRAIN);
    assign bus.done       = (r_state == S_DONE);
    assign bus.pass       = (r_state == S_DONE) && !r_fail;
    assign bus.fail       = r_fail;
    assign bus.err_lane   = r_err_lane;
    assign bus.err_count  = r_err_count;
    assign bus.ones_count = r_ones_count;
endmodule
